// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: data-memory access with ack timeout, then register-file write-back.
// Optional forwarding outputs (fwd_valid/fwd_addr/fwd_data) are enabled with `define MEM_WB_BYPASS_EN.
module mem_wb_stage #(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exm_valid,
    input  logic        exm_regwrite,
    input  logic        exm_memread,
    input  logic        exm_memwrite,
    input  logic        exm_memtoreg,
    input  logic [31:0] exm_alu_result,
    input  logic [31:0] exm_store_data,
    input  logic [4:0]  exm_dest,
    output logic        stall,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        wb_en,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
`ifdef MEM_WB_BYPASS_EN
    output logic        fwd_valid,
    output logic [4:0]  fwd_addr,
    output logic [31:0] fwd_data,
`endif
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACCESS    = 2'd1,
        WRITEBACK = 2'd2
    } state_t;

    // Counter value in the last permitted ACCESS cycle.
    localparam logic [7:0] LAST_CNT = 8'(ACK_TIMEOUT - 1);

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  cnt_q;
    logic        regwrite_q;
    logic        memtoreg_q;
    logic        is_load_q;
    logic [31:0] alu_q;

    logic        capture_alu;
    logic        capture_mem;
    logic        ack_done;
    logic        timeout;

    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        capture_alu = 1'b0;
        capture_mem = 1'b0;
        ack_done    = 1'b0;
        timeout     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (exm_valid) begin
                    if (exm_memread || exm_memwrite) begin
                        capture_mem = 1'b1;
                        state_d     = ACCESS;
                    end else begin
                        capture_alu = 1'b1;
                        state_d     = WRITEBACK;
                    end
                end
            end
            ACCESS: begin
                // An ack in the final counted cycle still wins over the timeout.
                if (dm_ack) begin
                    ack_done = 1'b1;
                    state_d  = WRITEBACK;
                end else if (cnt_q == LAST_CNT) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end
            end
            WRITEBACK: state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            is_load_q  <= 1'b0;
            alu_q      <= '0;
            dm_req     <= 1'b0;
            dm_we      <= 1'b0;
            dm_addr    <= '0;
            dm_wdata   <= '0;
            wb_addr    <= '0;
            wb_data    <= '0;
            err        <= 1'b0;
        end else begin
            if (capture_alu) begin
                regwrite_q <= exm_regwrite;
                wb_addr    <= exm_dest;
                wb_data    <= exm_alu_result;
            end
            if (capture_mem) begin
                regwrite_q <= exm_regwrite;
                memtoreg_q <= exm_memtoreg;
                is_load_q  <= exm_memread;
                alu_q      <= exm_alu_result;
                wb_addr    <= exm_dest;
                dm_req     <= 1'b1;
                // A combined read+write request is handled as a plain load.
                dm_we      <= exm_memwrite & ~exm_memread;
                dm_addr    <= exm_alu_result;
                dm_wdata   <= exm_store_data;
                cnt_q      <= '0;
            end
            if (ack_done) begin
                dm_req  <= 1'b0;
                dm_we   <= 1'b0;
                wb_data <= (is_load_q && memtoreg_q) ? dm_rdata : alu_q;
            end else if (timeout) begin
                dm_req     <= 1'b0;
                dm_we      <= 1'b0;
                regwrite_q <= 1'b0;
                err        <= 1'b1;
            end else if (state_q == ACCESS) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    assign stall = (state_q != IDLE);
    assign wb_en = (state_q == WRITEBACK) && regwrite_q && (wb_addr != 5'd0);

`ifdef MEM_WB_BYPASS_EN
    assign fwd_valid = wb_en;
    assign fwd_addr  = wb_addr;
    assign fwd_data  = wb_data;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed cases plus randomized instructions checked
// against a transaction-level model of access latency, timeout and write-back rules.
module tb_mem_wb_stage;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        exm_valid, exm_regwrite, exm_memread, exm_memwrite, exm_memtoreg;
    logic [31:0] exm_alu_result, exm_store_data;
    logic [4:0]  exm_dest;
    logic        stall, dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        err;
`ifdef MEM_WB_BYPASS_EN
    logic        fwd_valid;
    logic [4:0]  fwd_addr;
    logic [31:0] fwd_data;
`endif

    int   checks = 0;
    int   errors = 0;
    logic err_exp = 1'b0;

    always #5 clk = ~clk;

    mem_wb_stage #(.ACK_TIMEOUT(T)) dut (
        .clk            (clk),
        .rst            (rst),
        .exm_valid      (exm_valid),
        .exm_regwrite   (exm_regwrite),
        .exm_memread    (exm_memread),
        .exm_memwrite   (exm_memwrite),
        .exm_memtoreg   (exm_memtoreg),
        .exm_alu_result (exm_alu_result),
        .exm_store_data (exm_store_data),
        .exm_dest       (exm_dest),
        .stall          (stall),
        .dm_req         (dm_req),
        .dm_we          (dm_we),
        .dm_addr        (dm_addr),
        .dm_wdata       (dm_wdata),
        .dm_ack         (dm_ack),
        .dm_rdata       (dm_rdata),
        .wb_en          (wb_en),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
`ifdef MEM_WB_BYPASS_EN
        .fwd_valid      (fwd_valid),
        .fwd_addr       (fwd_addr),
        .fwd_data       (fwd_data),
`endif
        .err            (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Junk on the EX/MEM inputs while the stage is busy must never be captured.
    task automatic scramble_inputs;
        exm_regwrite   = 1'($urandom);
        exm_memread    = 1'($urandom);
        exm_memwrite   = 1'($urandom);
        exm_memtoreg   = 1'($urandom);
        exm_alu_result = $urandom;
        exm_store_data = $urandom;
        exm_dest       = 5'($urandom);
    endtask

    task automatic check_wb_cycle(input logic exp_en, input logic [4:0] dest, input logic [31:0] exp_data);
        check("wb_stall", stall, 1);
        check("wb_req", dm_req, 0);
        check("wb_en", wb_en, exp_en);
        if (exp_en) begin
            check("wb_addr", wb_addr, dest);
            check("wb_data", wb_data, exp_data);
        end
`ifdef MEM_WB_BYPASS_EN
        check("fwd_valid", fwd_valid, exp_en);
        check("fwd_data", fwd_data, wb_data);
`endif
        tick();
        check("wb_done_stall", stall, 0);
        check("wb_done_en", wb_en, 0);
    endtask

    // ack_lat: ACCESS cycle (1-based) in which dm_ack is raised; 0 or >T means never.
    task automatic run_op(input logic rd, input logic wr, input logic rw, input logic m2r,
                          input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] dest,
                          input int ack_lat, input logic [31:0] rdata);
        logic        is_mem;
        logic        completes;
        int          req_cycles;
        logic        exp_en;
        logic [31:0] exp_data;

        // A stray ack while idle must be ignored.
        dm_ack   = 1'($urandom);
        dm_rdata = $urandom;
        exm_valid = 1'b0;
        tick();
        dm_ack = 1'b0;
        check("idle_stall", stall, 0);
        check("idle_req", dm_req, 0);

        exm_valid      = 1'b1;
        exm_memread    = rd;
        exm_memwrite   = wr;
        exm_regwrite   = rw;
        exm_memtoreg   = m2r;
        exm_alu_result = alu;
        exm_store_data = sd;
        exm_dest       = dest;
        tick();
        exm_valid = 1'b0;
        scramble_inputs();

        is_mem = rd | wr;
        exp_en = rw && (dest != 5'd0);
        if (!is_mem) begin
            check_wb_cycle(exp_en, dest, alu);
        end else begin
            completes  = (ack_lat >= 1) && (ack_lat <= T);
            req_cycles = completes ? ack_lat : T;
            for (int c = 1; c <= req_cycles; c++) begin
                check("acc_req", dm_req, 1);
                check("acc_stall", stall, 1);
                check("acc_addr", dm_addr, alu);
                check("acc_we", dm_we, wr & ~rd);
                if (wr && !rd) check("acc_wdata", dm_wdata, sd);
                check("acc_wben", wb_en, 0);
                dm_ack   = (c == ack_lat);
                dm_rdata = (c == ack_lat) ? rdata : $urandom;
                tick();
                dm_ack = 1'b0;
            end
            check("post_req", dm_req, 0);
            if (completes) begin
                exp_data = (rd && m2r) ? rdata : alu;
                check_wb_cycle(exp_en, dest, exp_data);
            end else begin
                err_exp = 1'b1;
                check("to_stall", stall, 0);
                check("to_wben", wb_en, 0);
                tick();
                check("to_idle_wben", wb_en, 0);
            end
        end
        check("err", err, err_exp);
    endtask

    task automatic reset_mid_access;
        exm_valid      = 1'b1;
        exm_memread    = 1'b1;
        exm_memwrite   = 1'b0;
        exm_regwrite   = 1'b1;
        exm_memtoreg   = 1'b1;
        exm_alu_result = 32'h0000_0100;
        exm_dest       = 5'd9;
        tick();
        exm_valid = 1'b0;
        tick();
        tick();
        check("rma_req_before", dm_req, 1);
        #2 rst = 1'b0;
        #1;
        check("rma_req", dm_req, 0);
        check("rma_stall", stall, 0);
        check("rma_err", err, 0);
        check("rma_addr", dm_addr, 0);
        err_exp = 1'b0;
        #2 rst = 1'b1;
        tick();
        check("rma_discard_stall", stall, 0);
        check("rma_discard_wben", wb_en, 0);
        tick();
        check("rma_discard_req", dm_req, 0);
    endtask

    initial begin
        logic        rd, wr, rw, m2r;
        int          kind, r, lat;

        rst          = 1'b0;
        exm_valid    = 1'b0;
        dm_ack       = 1'b0;
        dm_rdata     = '0;
        scramble_inputs();
        #12;
        check("rst_stall", stall, 0);
        check("rst_req", dm_req, 0);
        check("rst_we", dm_we, 0);
        check("rst_wben", wb_en, 0);
        check("rst_err", err, 0);
        check("rst_addr", dm_addr, 0);
        check("rst_wdata", dm_wdata, 0);
        check("rst_wbaddr", wb_addr, 0);
        check("rst_wbdata", wb_data, 0);
        rst = 1'b1;
        tick();

        // Directed cases.
        run_op(0, 0, 1, 0, 32'h0000_1234, 32'h0, 5'd5, 0, 32'h0);
        run_op(1, 0, 1, 1, 32'h0000_0040, 32'h0, 5'd8, 3, 32'hDEAD_BEEF);
        run_op(0, 1, 0, 0, 32'h0000_0080, 32'hCAFE_0001, 5'd3, 1, 32'h0);
        run_op(0, 0, 1, 0, 32'h0000_5555, 32'h0, 5'd0, 0, 32'h0);
        run_op(1, 1, 1, 1, 32'h0000_00C0, 32'h1111_2222, 5'd7, 2, 32'h0BAD_F00D);
        run_op(1, 0, 1, 1, 32'h0000_0044, 32'h0, 5'd10, T, 32'h1357_9BDF);
        check("err_before_timeout", err, 0);
        run_op(1, 0, 1, 1, 32'h0000_0048, 32'h0, 5'd11, 0, 32'h0);
        run_op(0, 0, 1, 0, 32'h0000_7777, 32'h0, 5'd12, 0, 32'h0);
        reset_mid_access();

        // Randomized instruction stream.
        for (int i = 0; i < 150; i++) begin
            kind = int'($urandom_range(0, 3));
            rd   = (kind == 1) || (kind == 3);
            wr   = (kind == 2) || (kind == 3);
            rw   = 1'($urandom);
            m2r  = rd ? 1'($urandom) : 1'b0;
            r    = int'($urandom_range(0, 9));
            if (r == 0)      lat = 0;
            else if (r == 1) lat = T;
            else if (r == 2) lat = T + 1;
            else             lat = int'($urandom_range(1, 5));
            run_op(rd, wr, rw, m2r, $urandom, $urandom, 5'($urandom), lat, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
